lockstep_cmp: RTL and testbench

LOCKSTEP_CMP -- requirements
Module: lockstep_cmp

---
 rtl/lockstep_cmp.sv | 157 +++++++++++++++
 tb/tb_lockstep_cmp.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_cmp.sv
// Lockstep comparator for two time-aligned cores: compares OBI instruction/data requests
// every cycle, counts mismatches, captures the first one and latches a sticky fault.
//
// Request vector layout per core (REQ_W = 78 bits, core 0 in the low half, core 1 in the high half):
//   [77:70] other fields (ignored) | [69] req | [68:37] addr | [36] we | [35:32] be | [31:0] wdata
module lockstep_cmp #(
    parameter int NCYCLES         = 2,
    parameter int CNT_W           = 8,
    parameter int FAULT_THRESHOLD = 1,
    localparam int REQ_W          = 78
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic [2*REQ_W-1:0]   core_instr_req_i,
    input  logic [2*REQ_W-1:0]   core_data_req_i,
    output logic                 mismatch_o,
    output logic                 fault_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    output logic [1:0]           err_chan_o,
    output logic [31:0]          err_addr_o
);

    localparam int WDATA_LSB = 0;
    localparam int BE_LSB    = 32;
    localparam int WE_BIT    = 36;
    localparam int ADDR_LSB  = 37;
    localparam int REQ_BIT   = 69;

    localparam int ARM_W                = (NCYCLES > 1) ? $clog2(NCYCLES + 1) : 1;
    localparam logic [ARM_W-1:0] ARM_LD = ARM_W'(NCYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESHOLD);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARM      = 2'd1,
        CHECK    = 2'd2,
        FAULT    = 2'd3
    } state_e;

    state_e             state_q;
    logic [ARM_W-1:0]   arm_q;
    logic               mismatch_q;
    logic               fault_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [1:0]         err_chan_q;
    logic [31:0]        err_addr_q;

    logic               instr_mm;
    logic               data_mm;
    logic               any_mm;
    logic [CNT_W-1:0]   cnt_inc_d;
    logic [31:0]        cap_addr_d;

    // A channel differs if req differs, or an active request differs in addr/we/be,
    // or an active write differs in wdata. Stalls (gnt low) are still compared.
    function automatic logic chan_mismatch(input logic [REQ_W-1:0] a, input logic [REQ_W-1:0] b);
        logic diff;
        diff = 1'b0;
        if (a[REQ_BIT] != b[REQ_BIT]) begin
            diff = 1'b1;
        end else if (a[REQ_BIT]) begin
            if ((a[ADDR_LSB +: 32] != b[ADDR_LSB +: 32]) || (a[WE_BIT] != b[WE_BIT]) ||
                (a[BE_LSB +: 4] != b[BE_LSB +: 4])) begin
                diff = 1'b1;
            end else if (a[WE_BIT] && (a[WDATA_LSB +: 32] != b[WDATA_LSB +: 32])) begin
                diff = 1'b1;
            end else begin
                diff = 1'b0;
            end
        end else begin
            diff = 1'b0;
        end
        return diff;
    endfunction

    // Per-cycle channel comparison, saturating increment and capture address selection.
    always_comb begin
        instr_mm   = chan_mismatch(core_instr_req_i[REQ_W-1:0], core_instr_req_i[2*REQ_W-1:REQ_W]);
        data_mm    = chan_mismatch(core_data_req_i[REQ_W-1:0], core_data_req_i[2*REQ_W-1:REQ_W]);
        any_mm     = instr_mm | data_mm;
        cnt_inc_d  = (err_cnt_q == CNT_MAX) ? CNT_MAX : (err_cnt_q + CNT_W'(1));
        cap_addr_d = instr_mm ? core_instr_req_i[ADDR_LSB +: 32] : core_data_req_i[ADDR_LSB +: 32];
    end

    // Lockstep FSM with registered outputs; reset beats clear, clear beats any mismatch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= DISABLED;
            arm_q      <= '0;
            mismatch_q <= 1'b0;
            fault_q    <= 1'b0;
            err_cnt_q  <= '0;
            err_chan_q <= 2'b00;
            err_addr_q <= 32'h0000_0000;
        end else if (clear_i) begin
            mismatch_q <= 1'b0;
            fault_q    <= 1'b0;
            err_cnt_q  <= '0;
            err_chan_q <= 2'b00;
            err_addr_q <= 32'h0000_0000;
            arm_q      <= ARM_LD;
            state_q    <= enable_i ? ARM : DISABLED;
        end else begin
            mismatch_q <= 1'b0;
            if (((state_q == CHECK) || (state_q == FAULT)) && any_mm) begin
                mismatch_q <= 1'b1;
                err_cnt_q  <= cnt_inc_d;
                if (err_cnt_q == '0) begin
                    err_chan_q <= {data_mm, instr_mm};
                    err_addr_q <= cap_addr_d;
                end
            end
            case (state_q)
                DISABLED: begin
                    if (enable_i) begin
                        state_q <= ARM;
                        arm_q   <= ARM_LD;
                    end
                end
                ARM: begin
                    if (!enable_i) begin
                        state_q <= DISABLED;
                    end else if (arm_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        arm_q <= arm_q - ARM_W'(1);
                    end
                end
                CHECK: begin
                    if (any_mm && (cnt_inc_d >= THRESH)) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end else if (!enable_i) begin
                        state_q <= DISABLED;
                    end
                end
                FAULT: begin
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= DISABLED;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign mismatch_o = mismatch_q;
    assign fault_o    = fault_q;
    assign err_cnt_o  = err_cnt_q;
    assign err_chan_o = err_chan_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_lockstep_cmp.sv
// Bench for lockstep_cmp: directed scenarios with fixed expectations plus a randomized run
// scored against a cycle-level behavioural model. Instance a: THRESHOLD=1, CNT_W=8; b: THRESHOLD=3, CNT_W=2.
module tb_lockstep_cmp;

    typedef struct packed {
        logic [7:0]  other;
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    localparam int NCYC  = 2;
    localparam int S_DIS = 0;
    localparam int S_ARM = 1;
    localparam int S_CHK = 2;
    localparam int S_FLT = 3;

    logic clk = 1'b0;
    logic rst, en, clr;
    req_t ic0, ic1, dc0, dc1;
    logic [155:0] instr_vec, data_vec;
    logic        mm_a, fault_a, mm_b, fault_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;
    logic [1:0]  chan_a, chan_b;
    logic [31:0] addr_a, addr_b;

    logic        o_mm[2], o_fault[2];
    logic [7:0]  o_cnt[2];
    logic [1:0]  o_chan[2];
    logic [31:0] o_addr[2];

    int          m_st[2], m_seen[2], m_cnt[2];
    bit          m_mm[2];
    logic [1:0]  m_chan[2];
    logic [31:0] m_addr[2];
    int          m_thr[2] = '{1, 3};
    int          m_max[2] = '{255, 3};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instr_vec = {ic1, ic0};
    assign data_vec  = {dc1, dc0};

    lockstep_cmp #(.NCYCLES(NCYC), .CNT_W(8), .FAULT_THRESHOLD(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .core_instr_req_i(instr_vec), .core_data_req_i(data_vec),
        .mismatch_o(mm_a), .fault_o(fault_a), .err_cnt_o(cnt_a),
        .err_chan_o(chan_a), .err_addr_o(addr_a)
    );

    lockstep_cmp #(.NCYCLES(NCYC), .CNT_W(2), .FAULT_THRESHOLD(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .core_instr_req_i(instr_vec), .core_data_req_i(data_vec),
        .mismatch_o(mm_b), .fault_o(fault_b), .err_cnt_o(cnt_b),
        .err_chan_o(chan_b), .err_addr_o(addr_b)
    );

    assign o_mm[0] = mm_a;     assign o_mm[1] = mm_b;
    assign o_fault[0] = fault_a; assign o_fault[1] = fault_b;
    assign o_cnt[0] = cnt_a;   assign o_cnt[1] = {6'd0, cnt_b};
    assign o_chan[0] = chan_a; assign o_chan[1] = chan_b;
    assign o_addr[0] = addr_a; assign o_addr[1] = addr_b;

    // Mismatch rule applied directly to request fields.
    function automatic bit mm_f(input req_t a, input req_t b);
        if (a.req != b.req) return 1'b1;
        if (!a.req) return 1'b0;
        if (a.addr != b.addr || a.we != b.we || a.be != b.be) return 1'b1;
        return a.we && (a.wdata != b.wdata);
    endfunction

    // Advance the reference model by one clock using the inputs sampled at that edge.
    task automatic model_update();
        bit im, dm;
        im = mm_f(ic0, ic1);
        dm = mm_f(dc0, dc1);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_st[k] = S_DIS; m_seen[k] = 0; m_cnt[k] = 0; m_mm[k] = 1'b0;
                m_chan[k] = 2'b00; m_addr[k] = 32'h0;
            end else if (clr) begin
                m_st[k] = en ? S_ARM : S_DIS; m_seen[k] = 0; m_cnt[k] = 0; m_mm[k] = 1'b0;
                m_chan[k] = 2'b00; m_addr[k] = 32'h0;
            end else begin
                m_mm[k] = 1'b0;
                case (m_st[k])
                    S_DIS: if (en) begin m_st[k] = S_ARM; m_seen[k] = 0; end
                    S_ARM: begin
                        if (!en) m_st[k] = S_DIS;
                        else begin
                            m_seen[k]++;
                            if (m_seen[k] == NCYC + 1) m_st[k] = S_CHK;
                        end
                    end
                    default: begin
                        if (im || dm) begin
                            m_mm[k] = 1'b1;
                            if (m_cnt[k] == 0) begin
                                m_chan[k] = {dm, im};
                                m_addr[k] = im ? ic0.addr : dc0.addr;
                            end
                            m_cnt[k] = (m_cnt[k] < m_max[k]) ? m_cnt[k] + 1 : m_max[k];
                            if (m_st[k] == S_CHK && m_cnt[k] >= m_thr[k]) m_st[k] = S_FLT;
                        end
                        if (m_st[k] == S_CHK && !en) m_st[k] = S_DIS;
                    end
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic req_t rand_req(input bit req);
        req_t r;
        r.other = 8'($urandom); r.req = req; r.addr = $urandom; r.we = 1'($urandom);
        r.be = 4'($urandom); r.wdata = $urandom;
        return r;
    endfunction

    // Equal requests differing only in fields the comparator must ignore.
    task automatic set_ident();
        ic0 = rand_req(1'b1); ic0.we = 1'b0;
        ic1 = ic0; ic1.other = ~ic0.other; ic1.wdata = ~ic0.wdata;
        dc0 = rand_req(1'b0);
        dc1 = rand_req(1'b0);
    endtask

    task automatic set_data_mm(input logic [31:0] a);
        set_ident();
        dc0 = rand_req(1'b1); dc0.we = 1'b1; dc0.addr = a;
        dc1 = dc0; dc1.wdata = ~dc0.wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; set_ident();
        step(); step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_mm[k] !== 1'b0 || o_fault[k] !== 1'b0 || o_cnt[k] !== 8'd0 ||
                o_chan[k] !== 2'b00 || o_addr[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset[%0d]: got mm=%b f=%b cnt=%0d ch=%b addr=%h want all 0",
                         k, o_mm[k], o_fault[k], o_cnt[k], o_chan[k], o_addr[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_arm_and_first();
        en = 1'b1; set_ident();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mm_a !== 1'b0 || cnt_a !== 8'd0 || mm_b !== 1'b0) begin
                errors++; $display("FAIL arm_quiet c%0d: got mm=%b cnt=%0d want 0 0", i, mm_a, cnt_a);
            end
        end
        set_data_mm(32'h0000_2000);
        step();
        checks++;
        if (mm_a !== 1'b0 || cnt_a !== 8'd0) begin
            errors++; $display("FAIL arm_last_ignored: got mm=%b cnt=%0d want 0 0", mm_a, cnt_a);
        end
        set_ident();
        dc0 = rand_req(1'b1); dc0.we = 1'b1; dc0.addr = 32'h0000_1000; dc0.wdata = 32'h0000_00A5;
        dc1 = dc0; dc1.wdata = 32'h0000_005A;
        step();
        checks++;
        if (mm_a !== 1'b1 || cnt_a !== 8'd1 || chan_a !== 2'b10 || addr_a !== 32'h1000 || fault_a !== 1'b1) begin
            errors++;
            $display("FAIL first_mm_a: got mm=%b cnt=%0d ch=%b addr=%h f=%b want 1 1 10 1000 1",
                     mm_a, cnt_a, chan_a, addr_a, fault_a);
        end
        checks++;
        if (cnt_b !== 2'd1 || fault_b !== 1'b0) begin
            errors++; $display("FAIL first_mm_b: got cnt=%0d f=%b want 1 0", cnt_b, fault_b);
        end
        set_ident();
        step();
        checks++;
        if (mm_a !== 1'b0 || cnt_a !== 8'd1 || fault_a !== 1'b1) begin
            errors++; $display("FAIL pulse_one: got mm=%b cnt=%0d f=%b want 0 1 1", mm_a, cnt_a, fault_a);
        end
    endtask

    task automatic clear_and_arm();
        clr = 1'b1; en = 1'b1; set_ident();
        step();
        clr = 1'b0;
        checks++;
        if (cnt_b !== 2'd0 || chan_b !== 2'b00 || addr_b !== 32'h0 || fault_a !== 1'b0 || cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL clear: got cnt_b=%0d ch=%b addr=%h fa=%b cnt_a=%0d want 0", cnt_b, chan_b, addr_b, fault_a, cnt_a);
        end
        step(); step(); step();
    endtask

    task automatic test_threshold();
        logic [31:0] addrs [3];
        addrs = '{32'h10, 32'h20, 32'h30};
        clear_and_arm();
        for (int i = 0; i < 3; i++) begin
            set_data_mm(addrs[i]);
            step();
            checks++;
            if (mm_b !== 1'b1 || cnt_b !== 2'(i + 1) || addr_b !== 32'h10 || fault_b !== (i == 2)) begin
                errors++;
                $display("FAIL threshold%0d: got mm=%b cnt=%0d addr=%h f=%b want 1 %0d 10 %0d",
                         i, mm_b, cnt_b, addr_b, fault_b, i + 1, i == 2);
            end
        end
    endtask

    task automatic test_both_channels();
        clear_and_arm();
        set_data_mm(32'h0000_0800);
        ic0.addr = 32'h0000_0400; ic1 = ic0; ic1.be = ~ic0.be;
        step();
        checks++;
        if (cnt_b !== 2'd1 || chan_b !== 2'b11 || addr_b !== 32'h400 || cnt_a !== 8'd1 || chan_a !== 2'b11) begin
            errors++;
            $display("FAIL both_chan: got cnt=%0d ch=%b addr=%h cnt_a=%0d want 1 11 400 1", cnt_b, chan_b, addr_b, cnt_a);
        end
    endtask

    task automatic test_saturate_clear();
        for (int i = 0; i < 7; i++) begin
            set_data_mm($urandom);
            step();
            checks++;
            if (cnt_b !== 2'((2 + i > 3) ? 3 : 2 + i) || fault_b !== (2 + i >= 3) || addr_b !== 32'h400) begin
                errors++;
                $display("FAIL saturate%0d: got cnt=%0d f=%b addr=%h want %0d %0d 400",
                         i, cnt_b, fault_b, addr_b, (2 + i > 3) ? 3 : 2 + i, 2 + i >= 3);
            end
        end
        clr = 1'b1; en = 1'b1; set_data_mm(32'h0000_0044);
        step();
        clr = 1'b0;
        checks++;
        if (cnt_b !== 2'd0 || mm_b !== 1'b0 || fault_b !== 1'b0 || mm_a !== 1'b0 || cnt_a !== 8'd0) begin
            errors++; $display("FAIL clear_wins: got cnt=%0d mm=%b f=%b want 0 0 0", cnt_b, mm_b, fault_b);
        end
        step();
        checks++;
        if (mm_b !== 1'b0 || cnt_b !== 2'd0) begin
            errors++; $display("FAIL clear_to_arm: got mm=%b cnt=%0d want 0 0", mm_b, cnt_b);
        end
    endtask

    task automatic test_disable_hold();
        set_ident(); step(); step();
        set_data_mm(32'h0000_055C);
        step();
        en = 1'b0; set_ident();
        step();
        set_data_mm(32'h0000_0ABC);
        step();
        checks++;
        if (mm_b !== 1'b0 || cnt_b !== 2'd1 || addr_b !== 32'h55C || fault_b !== 1'b0) begin
            errors++; $display("FAIL disable_hold: got mm=%b cnt=%0d addr=%h f=%b want 0 1 55c 0", mm_b, cnt_b, addr_b, fault_b);
        end
        checks++;
        if (fault_a !== 1'b1 || cnt_a !== 8'd2 || mm_a !== 1'b1) begin
            errors++; $display("FAIL fault_ignores_en: got f=%b cnt=%0d mm=%b want 1 2 1", fault_a, cnt_a, mm_a);
        end
    endtask

    task automatic test_reset_in_fault();
        rst = 1'b1; en = 1'b1; set_data_mm(32'h0000_0777);
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_mm[k] !== 1'b0 || o_fault[k] !== 1'b0 || o_cnt[k] !== 8'd0 || o_chan[k] !== 2'b00 || o_addr[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_fault[%0d]: got mm=%b f=%b cnt=%0d ch=%b addr=%h want all 0",
                         k, o_mm[k], o_fault[k], o_cnt[k], o_chan[k], o_addr[k]);
            end
        end
        step();
        checks++;
        if (mm_a !== 1'b0 || cnt_a !== 8'd0) begin
            errors++; $display("FAIL reset_then_disabled: got mm=%b cnt=%0d want 0 0", mm_a, cnt_a);
        end
    endtask

    task automatic rand_pair(output req_t a, output req_t b);
        a = rand_req($urandom_range(0, 4) != 0);
        b = a;
        case ($urandom_range(0, 11))
            0: b.req = ~a.req;
            1: b.addr = a.addr ^ (32'd1 << $urandom_range(0, 31));
            2: b.we = ~a.we;
            3: b.be = a.be ^ 4'(1 << $urandom_range(0, 3));
            4: b.wdata = a.wdata ^ (32'd1 << $urandom_range(0, 31));
            5: b.other = ~a.other;
            default: b = a;
        endcase
    endtask

    task automatic test_random();
        rst = 1'b1; clr = 1'b0; en = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rand_pair(ic0, ic1);
            rand_pair(dc0, dc1);
            if ($urandom_range(0, 39) == 0) en = ~en;
            clr = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_mm[k] !== m_mm[k] || o_fault[k] !== (m_st[k] == S_FLT) || o_cnt[k] !== 8'(m_cnt[k]) ||
                    o_chan[k] !== m_chan[k] || o_addr[k] !== m_addr[k]) begin
                    errors++;
                    $display("FAIL random[%0d] cyc %0d: got mm=%b f=%b cnt=%0d ch=%b addr=%h want %b %b %0d %b %h",
                             k, c, o_mm[k], o_fault[k], o_cnt[k], o_chan[k], o_addr[k],
                             m_mm[k], m_st[k] == S_FLT, m_cnt[k], m_chan[k], m_addr[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arm_and_first();
        test_threshold();
        test_both_channels();
        test_saturate_clear();
        test_disable_hold();
        test_reset_in_fault();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
